// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: font table, scan FSM states and segment-off constant for seg_scan_ctrl
package seg_pkg;
  typedef enum logic {GUARD, DWELL} state_t;
  localparam logic [7:0] SEG_OFF = 8'hff;
  localparam logic [15:0][7:0] FONT = {
    8'hbf, 8'h86, 8'ha1, 8'hc6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hf8, 8'h82, 8'h92, 8'h99, 8'hb0, 8'ha4, 8'hf9, 8'hc0
  };
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: display data/load bus and scan outputs; blink_mask exists only with SEG_BLINK_EN
interface seg_scan_ctrl_if #(parameter int NUM_DIGITS = 8);
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0] dp;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic load;
`ifdef SEG_BLINK_EN
  logic [NUM_DIGITS-1:0] blink_mask;
`endif
  logic [NUM_DIGITS-1:0] sel;
  logic [7:0] seg;
  logic frame_done;
  modport master(
`ifdef SEG_BLINK_EN
    output blink_mask,
`endif
    output data, dp, blank_mask, load,
    input sel, seg, frame_done
  );
  modport slave(
`ifdef SEG_BLINK_EN
    input blink_mask,
`endif
    input data, dp, blank_mask, load,
    output sel, seg, frame_done
  );
endinterface

// File: rtl/seg_font_dec.sv
// seg_font_dec: hex nibble + dp to 8-bit segment pattern in the requested polarity
module seg_font_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       active_low,
  output logic [7:0] seg
);
  logic [7:0] raw;
  assign raw = {~dp, FONT[nibble][6:0]};
  assign seg = active_low ? raw : ~raw;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner with guard blanking and tear-free shadow frames.
// Optional digit blinking is built when SEG_BLINK_EN is defined.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 4,
  parameter bit SEG_ACTIVE_LOW = 1,
  parameter bit SEL_ACTIVE_LOW = 0
`ifdef SEG_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
)(
  input logic clk,
  input logic rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [7:0] OFF = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx, ridx;
  state_t state, state_n;
  logic [4*NUM_DIGITS-1:0] pend_data, shad_data;
  logic [NUM_DIGITS-1:0] pend_dp, shad_dp, pend_blank, shad_blank, one, sel_n;
  logic [3:0] nib;
  logic [7:0] font_seg, seg_n;
  logic slot_end, frame_end, dark, show;
  assign slot_end  = cnt == CW'(SCAN_DIV - 1);
  assign frame_end = slot_end && idx == IW'(NUM_DIGITS - 1);
  assign ridx = IW'(NUM_DIGITS - 1) - idx;
  assign nib  = shad_data[{ridx, 2'b00} +: 4];
  assign one  = NUM_DIGITS'(1) << idx;
  seg_font_dec u_font (.nibble(nib), .dp(shad_dp[idx]), .active_low(SEG_ACTIVE_LOW), .seg(font_seg));
`ifdef SEG_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [FW-1:0] fcnt;
  logic blink_off;
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt      <= '0;
      blink_off <= 1'b0;
    end else if (frame_end) begin
      fcnt      <= (fcnt == FW'(BLINK_FRAMES - 1)) ? '0 : fcnt + 1'b1;
      blink_off <= (fcnt == FW'(BLINK_FRAMES - 1)) ? ~blink_off : blink_off;
    end
  end
  assign dark = blink_off & bus.blink_mask[idx];
`else
  assign dark = 1'b0;
`endif
  always_comb begin
    state_n = slot_end ? GUARD : (cnt == CW'(BLANK_CYCLES - 1)) ? DWELL : state;
    show    = state == DWELL && !shad_blank[idx] && !dark;
    sel_n   = show ? one : '0;
    seg_n   = show ? font_seg : OFF;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= GUARD;
    else     state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      idx            <= '0;
      pend_data      <= '0;
      pend_dp        <= '0;
      pend_blank     <= '0;
      shad_data      <= '0;
      shad_dp        <= '0;
      shad_blank     <= '0;
      bus.sel        <= SEL_ACTIVE_LOW ? '1 : '0;
      bus.seg        <= OFF;
      bus.frame_done <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      idx <= frame_end ? '0 : slot_end ? idx + 1'b1 : idx;
      if (bus.load) begin
        pend_data  <= bus.data;
        pend_dp    <= bus.dp;
        pend_blank <= bus.blank_mask;
      end
      // a load coinciding with the frame boundary bypasses pending
      if (frame_end) begin
        shad_data  <= bus.load ? bus.data : pend_data;
        shad_dp    <= bus.load ? bus.dp : pend_dp;
        shad_blank <= bus.load ? bus.blank_mask : pend_blank;
      end
      bus.sel        <= SEL_ACTIVE_LOW ? ~sel_n : sel_n;
      bus.seg        <= seg_n;
      bus.frame_done <= frame_end;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed vector table plus multi-cycle corner sequences for seg_scan_ctrl
module tb_seg_scan_ctrl;
  typedef struct {
    logic [15:0]      data;
    logic [3:0]       dp;
    logic [3:0]       blank;
    logic [3:0][7:0]  seg;
    logic [3:0]       on;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  vec_t vecs[5];
  seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus();
  seg_scan_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)
`ifdef SEG_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  // j is the 1-based frame position reflected by the registered outputs after each edge
  task automatic steps(input logic [3:0][7:0] es, input logic [3:0] on, input int from, input int to, input string nm);
    for (int j = from; j <= to; j++) begin
      int d, c;
      logic lit;
      logic [7:0] xs, xg;
      @(posedge clk);
      @(negedge clk);
      d   = (j - 1) / 8;
      c   = (j - 1) % 8;
      lit = c >= 2 && on[d];
      xs  = lit ? 8'(1 << d) : 8'h00;
      xg  = lit ? es[d] : 8'hff;
      chk($sformatf("%s_sel_j%0d", nm, j), {4'h0, bus.sel}, xs);
      chk($sformatf("%s_seg_j%0d", nm, j), bus.seg, xg);
      chk($sformatf("%s_fd_j%0d", nm, j), {7'h0, bus.frame_done}, {7'h0, j == 32});
    end
  endtask
  task automatic drive(input logic ld, input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    bus.load = ld;
    bus.data = d;
    bus.dp = p;
    bus.blank_mask = b;
  endtask
  task automatic reset_check(input string nm);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_sel"}, {4'h0, bus.sel}, 8'h00);
    chk({nm, "_seg"}, bus.seg, 8'hff);
    chk({nm, "_fd"}, {7'h0, bus.frame_done}, 8'h00);
    rst = 1'b0;
  endtask
  localparam logic [3:0][7:0] ZEROS = {8'hc0, 8'hc0, 8'hc0, 8'hc0};
  localparam logic [3:0][7:0] THREES = {8'hb0, 8'hb0, 8'hb0, 8'hb0};
  localparam logic [3:0][7:0] F4567 = {8'hf8, 8'h82, 8'h92, 8'h99};
  initial begin
    logic [3:0][7:0] pseg;
    logic [3:0] pon;
    vecs[0] = '{16'h12F0, 4'b0000, 4'b0000, {8'hc0, 8'hbf, 8'ha4, 8'hf9}, 4'b1111};
    vecs[1] = '{16'h3333, 4'b0000, 4'b0000, THREES, 4'b1111};
    vecs[2] = '{16'h1456, 4'b0001, 4'b0010, {8'h82, 8'h92, 8'hff, 8'h79}, 4'b1101};
    vecs[3] = '{16'h789A, 4'b1010, 4'b0000, {8'h08, 8'h90, 8'h00, 8'hf8}, 4'b1111};
    vecs[4] = '{16'hBCDE, 4'b0000, 4'b1001, {8'hff, 8'ha1, 8'hc6, 8'hff}, 4'b0110};
    drive(1'b0, 16'h0, 4'h0, 4'h0);
`ifdef SEG_BLINK_EN
    bus.blink_mask = 4'b0000;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    reset_check("reset");
    steps(ZEROS, 4'b1111, 1, 32, "post_reset");
    pseg = ZEROS;
    pon  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      steps(pseg, pon, 1, 9, $sformatf("v%0d_pre", i));
      drive(1'b1, vecs[i].data, vecs[i].dp, vecs[i].blank);
      steps(pseg, pon, 10, 10, $sformatf("v%0d_ld", i));
      drive(1'b0, 16'h0, 4'h0, 4'hf);
      steps(pseg, pon, 11, 32, $sformatf("v%0d_old", i));
      pseg = vecs[i].seg;
      pon  = vecs[i].on;
    end
    steps(pseg, pon, 1, 32, "v4_frame");
    steps(pseg, pon, 1, 19, "mid_old");
    drive(1'b1, 16'h3333, 4'h0, 4'h0);
    steps(pseg, pon, 20, 20, "mid_ld");
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    steps(pseg, pon, 21, 32, "mid_tail");
    steps(THREES, 4'b1111, 1, 4, "multi_a");
    drive(1'b1, 16'h9999, 4'hf, 4'h0);
    steps(THREES, 4'b1111, 5, 5, "multi_b");
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    steps(THREES, 4'b1111, 6, 11, "multi_c");
    drive(1'b1, 16'h4567, 4'h0, 4'h0);
    steps(THREES, 4'b1111, 12, 12, "multi_d");
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    steps(THREES, 4'b1111, 13, 32, "multi_e");
    steps(F4567, 4'b1111, 1, 31, "last_wins");
    drive(1'b1, vecs[0].data, 4'h0, 4'h0);
    steps(F4567, 4'b1111, 32, 32, "bound_ld");
    drive(1'b0, 16'h0, 4'h0, 4'h0);
    steps(vecs[0].seg, 4'b1111, 1, 32, "bound_new");
    steps(vecs[0].seg, 4'b1111, 1, 30, "pre_rst");
    reset_check("mid_rst");
    steps(ZEROS, 4'b1111, 1, 32, "after_rst");
`ifdef SEG_BLINK_EN
    bus.blink_mask = 4'b1000;
    reset_check("blink_rst");
    steps(ZEROS, 4'b1111, 1, 32, "blink_f1");
    steps(ZEROS, 4'b1111, 1, 32, "blink_f2");
    steps(ZEROS, 4'b0111, 1, 32, "blink_f3");
    steps(ZEROS, 4'b0111, 1, 32, "blink_f4");
    steps(ZEROS, 4'b1111, 1, 32, "blink_f5");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
